// File: rtl/riscv_base_writeback.sv
// Writeback stage for a simple in-order RISC-V core: two-stage ALU/MUL result pipe,
// one outstanding divide with a single-entry skid, and issue-side RAW/structural stall.
module riscv_base_writeback #(
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hold_i,
  input  logic        issue_valid_i,
  input  logic        issue_mul_i,
  input  logic        issue_div_i,
  input  logic [4:0]  issue_rd_idx_i,
  input  logic [4:0]  issue_ra_idx_i,
  input  logic [4:0]  issue_rb_idx_i,
  input  logic [31:0] alu_value_i,
  input  logic [31:0] mul_value_i,
  input  logic        div_valid_i,
  input  logic [31:0] div_value_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic [31:0] wb_value_o
);

  if (MUL_LATENCY != 2) begin : g_latency_check
    $error("riscv_base_writeback: only MUL_LATENCY == 2 is supported");
  end

  logic        e1_valid_q, e1_valid_d;
  logic        e1_mul_q,   e1_mul_d;
  logic [4:0]  e1_rd_q,    e1_rd_d;
  logic [31:0] e1_value_q, e1_value_d;

  logic        e2_valid_q, e2_valid_d;
  logic        e2_mul_q,   e2_mul_d;
  logic [4:0]  e2_rd_q,    e2_rd_d;
  logic [31:0] e2_value_q, e2_value_d;

  logic        div_pending_q, div_pending_d;
  logic [4:0]  div_rd_q,      div_rd_d;

  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_value_q, skid_value_d;

  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q,    wb_rd_d;
  logic [31:0] wb_value_q, wb_value_d;

  logic        hazard_a;
  logic        hazard_b;
  logic        div_busy;
  logic        accept;
  logic        div_fire;

  // A source only hazards against producers whose value is not yet known at issue.
  assign hazard_a = (issue_ra_idx_i != 5'd0) &&
                    ((e1_valid_q && e1_mul_q && (issue_ra_idx_i == e1_rd_q)) ||
                     (e2_valid_q && e2_mul_q && (issue_ra_idx_i == e2_rd_q)) ||
                     (div_pending_q && (issue_ra_idx_i == div_rd_q)));
  assign hazard_b = (issue_rb_idx_i != 5'd0) &&
                    ((e1_valid_q && e1_mul_q && (issue_rb_idx_i == e1_rd_q)) ||
                     (e2_valid_q && e2_mul_q && (issue_rb_idx_i == e2_rd_q)) ||
                     (div_pending_q && (issue_rb_idx_i == div_rd_q)));
  assign div_busy = issue_div_i && div_pending_q;

  assign stall_o  = div_busy || hazard_a || hazard_b || skid_valid_q;
  assign accept   = issue_valid_i && !stall_o && !hold_i;
  assign div_fire = div_valid_i && div_pending_q;

  always_comb begin
    e1_valid_d    = e1_valid_q;
    e1_mul_d      = e1_mul_q;
    e1_rd_d       = e1_rd_q;
    e1_value_d    = e1_value_q;
    e2_valid_d    = e2_valid_q;
    e2_mul_d      = e2_mul_q;
    e2_rd_d       = e2_rd_q;
    e2_value_d    = e2_value_q;
    div_pending_d = div_pending_q;
    div_rd_d      = div_rd_q;
    skid_valid_d  = skid_valid_q;
    skid_value_d  = skid_value_q;
    wb_valid_d    = wb_valid_q;
    wb_rd_d       = wb_rd_q;
    wb_value_d    = wb_value_q;

    if (!hold_i) begin
      e1_valid_d = accept && !issue_div_i;
      e1_mul_d   = issue_mul_i;
      e1_rd_d    = issue_rd_idx_i;
      e1_value_d = alu_value_i;
      e2_valid_d = e1_valid_q;
      e2_mul_d   = e1_mul_q;
      e2_rd_d    = e1_rd_q;
      e2_value_d = e1_value_q;

      if (e2_valid_q) begin
        wb_valid_d = (e2_rd_q != 5'd0);
        wb_rd_d    = e2_rd_q;
        wb_value_d = e2_mul_q ? mul_value_i : e2_value_q;
        if (div_fire && !skid_valid_q) begin
          skid_valid_d = 1'b1;
          skid_value_d = div_value_i;
        end
      end else if (skid_valid_q) begin
        wb_valid_d    = (div_rd_q != 5'd0);
        wb_rd_d       = div_rd_q;
        wb_value_d    = skid_value_q;
        skid_valid_d  = 1'b0;
        div_pending_d = 1'b0;
      end else if (div_fire) begin
        wb_valid_d    = (div_rd_q != 5'd0);
        wb_rd_d       = div_rd_q;
        wb_value_d    = div_value_i;
        div_pending_d = 1'b0;
      end else begin
        wb_valid_d = 1'b0;
      end
    end else if (div_fire && !skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_value_d = div_value_i;
    end

    // A new divide can only be accepted once the previous one has retired.
    if (accept && issue_div_i) begin
      div_pending_d = 1'b1;
      div_rd_d      = issue_rd_idx_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      e1_valid_q    <= 1'b0;
      e1_mul_q      <= 1'b0;
      e1_rd_q       <= '0;
      e1_value_q    <= '0;
      e2_valid_q    <= 1'b0;
      e2_mul_q      <= 1'b0;
      e2_rd_q       <= '0;
      e2_value_q    <= '0;
      div_pending_q <= 1'b0;
      div_rd_q      <= '0;
      skid_valid_q  <= 1'b0;
      skid_value_q  <= '0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_value_q    <= '0;
    end else begin
      e1_valid_q    <= e1_valid_d;
      e1_mul_q      <= e1_mul_d;
      e1_rd_q       <= e1_rd_d;
      e1_value_q    <= e1_value_d;
      e2_valid_q    <= e2_valid_d;
      e2_mul_q      <= e2_mul_d;
      e2_rd_q       <= e2_rd_d;
      e2_value_q    <= e2_value_d;
      div_pending_q <= div_pending_d;
      div_rd_q      <= div_rd_d;
      skid_valid_q  <= skid_valid_d;
      skid_value_q  <= skid_value_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_value_q    <= wb_value_d;
    end
  end

  // The write port stays frozen under hold; the enable is masked so nothing commits twice.
  assign wb_valid_o  = wb_valid_q && !hold_i;
  assign wb_rd_idx_o = wb_rd_q;
  assign wb_value_o  = wb_value_q;

endmodule

// File: tb/tb_riscv_base_writeback.sv
// Directed self-checking bench for riscv_base_writeback; one task per scenario.
module tb_riscv_base_writeback;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        hold_i;
  logic        issue_valid_i;
  logic        issue_mul_i;
  logic        issue_div_i;
  logic [4:0]  issue_rd_idx_i;
  logic [4:0]  issue_ra_idx_i;
  logic [4:0]  issue_rb_idx_i;
  logic [31:0] alu_value_i;
  logic [31:0] mul_value_i;
  logic        div_valid_i;
  logic [31:0] div_value_i;
  logic        stall_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_idx_o;
  logic [31:0] wb_value_o;

  int unsigned tests = 0;
  int unsigned fails = 0;

  riscv_base_writeback #(.MUL_LATENCY(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .hold_i         (hold_i),
    .issue_valid_i  (issue_valid_i),
    .issue_mul_i    (issue_mul_i),
    .issue_div_i    (issue_div_i),
    .issue_rd_idx_i (issue_rd_idx_i),
    .issue_ra_idx_i (issue_ra_idx_i),
    .issue_rb_idx_i (issue_rb_idx_i),
    .alu_value_i    (alu_value_i),
    .mul_value_i    (mul_value_i),
    .div_valid_i    (div_valid_i),
    .div_value_i    (div_value_i),
    .stall_o        (stall_o),
    .wb_valid_o     (wb_valid_o),
    .wb_rd_idx_o    (wb_rd_idx_o),
    .wb_value_o     (wb_value_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    hold_i = 1'b0; issue_valid_i = 1'b0; issue_mul_i = 1'b0; issue_div_i = 1'b0;
    issue_rd_idx_i = '0; issue_ra_idx_i = '0; issue_rb_idx_i = '0;
    alu_value_i = '0; div_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    idle(); mul_value_i = '0; div_value_i = '0; rst_i = 1'b0;
    tick(); tick(); settle();
    tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL reset_wb_valid got %0b exp 0", wb_valid_o); end
    tests++; if (wb_rd_idx_o !== 5'd0) begin fails++; $display("FAIL reset_wb_rd got %0d exp 0", wb_rd_idx_o); end
    tests++; if (wb_value_o !== 32'h0) begin fails++; $display("FAIL reset_wb_value got %h exp 0", wb_value_o); end
    rst_i = 1'b1;
    tick(); settle();
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall got %0b exp 0", stall_o); end
  endtask

  task automatic test_alu();
    idle(); issue_valid_i = 1'b1; issue_rd_idx_i = 5'd5; alu_value_i = 32'h1234; settle();
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL alu_stall got %0b exp 0", stall_o); end
    tick(); idle(); settle();
    tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL alu_early1 got %0b exp 0", wb_valid_o); end
    tick(); settle();
    tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL alu_early2 got %0b exp 0", wb_valid_o); end
    tick(); settle();
    tests++; if (wb_valid_o !== 1'b1) begin fails++; $display("FAIL alu_wb_valid got %0b exp 1", wb_valid_o); end
    tests++; if (wb_rd_idx_o !== 5'd5) begin fails++; $display("FAIL alu_wb_rd got %0d exp 5", wb_rd_idx_o); end
    tests++; if (wb_value_o !== 32'h1234) begin fails++; $display("FAIL alu_wb_value got %h exp 1234", wb_value_o); end
    tick(); settle();
    tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL alu_release got %0b exp 0", wb_valid_o); end
    tests++; if (wb_rd_idx_o !== 5'd5 || wb_value_o !== 32'h1234) begin fails++;
      $display("FAIL alu_hold_data got rd=%0d val=%h exp rd=5 val=1234", wb_rd_idx_o, wb_value_o); end
  endtask

  task automatic test_mul();
    idle(); issue_valid_i = 1'b1; issue_mul_i = 1'b1; issue_rd_idx_i = 5'd7;
    issue_ra_idx_i = 5'd1; issue_rb_idx_i = 5'd2; alu_value_i = 32'hDEAD; mul_value_i = 32'hBAD; settle();
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL mul_issue_stall got %0b exp 0", stall_o); end
    tick(); idle(); issue_valid_i = 1'b1; issue_mul_i = 1'b1; issue_rd_idx_i = 5'd8;
    issue_ra_idx_i = 5'd7; settle();
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL mul_raw_e1 got %0b exp 1", stall_o); end
    tick(); mul_value_i = 32'hF; settle();
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL mul_raw_e2 got %0b exp 1", stall_o); end
    tick(); mul_value_i = 32'hBAD; settle();
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL mul_raw_clear got %0b exp 0", stall_o); end
    tests++; if (wb_valid_o !== 1'b1 || wb_rd_idx_o !== 5'd7 || wb_value_o !== 32'hF) begin fails++;
      $display("FAIL mul_wb got v=%0b rd=%0d val=%h exp v=1 rd=7 val=f", wb_valid_o, wb_rd_idx_o, wb_value_o); end
    tick(); idle(); settle();
    tick(); mul_value_i = 32'h21; settle();
    tick(); mul_value_i = 32'hBAD; settle();
    tests++; if (wb_valid_o !== 1'b1 || wb_rd_idx_o !== 5'd8 || wb_value_o !== 32'h21) begin fails++;
      $display("FAIL mul_second_wb got v=%0b rd=%0d val=%h exp v=1 rd=8 val=21", wb_valid_o, wb_rd_idx_o, wb_value_o); end
    tick(); settle();
  endtask

  task automatic test_div_collision();
    idle(); issue_valid_i = 1'b1; issue_div_i = 1'b1; issue_rd_idx_i = 5'd3; settle();
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL divc_issue_stall got %0b exp 0", stall_o); end
    tick(); idle(); issue_valid_i = 1'b1; issue_rd_idx_i = 5'd4; alu_value_i = 32'h44; settle();
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL divc_alu_stall got %0b exp 0", stall_o); end
    tick(); idle(); settle();
    tick(); div_valid_i = 1'b1; div_value_i = 32'h9; settle();
    tick(); idle(); issue_valid_i = 1'b1; issue_rd_idx_i = 5'd9; alu_value_i = 32'h99; settle();
    tests++; if (wb_valid_o !== 1'b1 || wb_rd_idx_o !== 5'd4 || wb_value_o !== 32'h44) begin fails++;
      $display("FAIL divc_alu_first got v=%0b rd=%0d val=%h exp v=1 rd=4 val=44", wb_valid_o, wb_rd_idx_o, wb_value_o); end
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL divc_skid_stall got %0b exp 1", stall_o); end
    tick(); settle();
    tests++; if (wb_valid_o !== 1'b1 || wb_rd_idx_o !== 5'd3 || wb_value_o !== 32'h9) begin fails++;
      $display("FAIL divc_div_second got v=%0b rd=%0d val=%h exp v=1 rd=3 val=9", wb_valid_o, wb_rd_idx_o, wb_value_o); end
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL divc_skid_release got %0b exp 0", stall_o); end
    tick(); idle(); settle();
    tick(); settle();
    tick(); settle();
    tests++; if (wb_valid_o !== 1'b1 || wb_rd_idx_o !== 5'd9 || wb_value_o !== 32'h99) begin fails++;
      $display("FAIL divc_retry_wb got v=%0b rd=%0d val=%h exp v=1 rd=9 val=99", wb_valid_o, wb_rd_idx_o, wb_value_o); end
    tick(); settle();
  endtask

  task automatic test_hold();
    idle(); issue_valid_i = 1'b1; issue_mul_i = 1'b1; issue_rd_idx_i = 5'd10; mul_value_i = 32'h55; settle();
    for (int i = 0; i < 3; i++) begin
      tick(); idle(); hold_i = 1'b1; settle();
      tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL hold_quiet%0d got %0b exp 0", i, wb_valid_o); end
    end
    tick(); idle(); settle();
    tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL hold_after1 got %0b exp 0", wb_valid_o); end
    tick(); settle();
    tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL hold_after2 got %0b exp 0", wb_valid_o); end
    tick(); settle();
    tests++; if (wb_valid_o !== 1'b1 || wb_rd_idx_o !== 5'd10 || wb_value_o !== 32'h55) begin fails++;
      $display("FAIL hold_wb got v=%0b rd=%0d val=%h exp v=1 rd=10 val=55", wb_valid_o, wb_rd_idx_o, wb_value_o); end
    tick(); idle(); issue_valid_i = 1'b1; issue_div_i = 1'b1; issue_rd_idx_i = 5'd11; settle();
    tick(); idle(); hold_i = 1'b1; div_valid_i = 1'b1; div_value_i = 32'h77; settle();
    tick(); idle(); hold_i = 1'b1; settle();
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL hold_skid_stall got %0b exp 1", stall_o); end
    tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL hold_skid_quiet got %0b exp 0", wb_valid_o); end
    tick(); idle(); settle();
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL hold_skid_stall2 got %0b exp 1", stall_o); end
    tick(); settle();
    tests++; if (wb_valid_o !== 1'b1 || wb_rd_idx_o !== 5'd11 || wb_value_o !== 32'h77) begin fails++;
      $display("FAIL hold_skid_wb got v=%0b rd=%0d val=%h exp v=1 rd=11 val=77", wb_valid_o, wb_rd_idx_o, wb_value_o); end
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL hold_skid_release got %0b exp 0", stall_o); end
    tick(); settle();
  endtask

  task automatic test_x0();
    idle(); issue_valid_i = 1'b1; issue_rd_idx_i = 5'd0; alu_value_i = 32'h1; settle();
    for (int i = 0; i < 4; i++) begin
      tick(); idle(); settle();
      tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL x0_no_write%0d got %0b exp 0", i, wb_valid_o); end
    end
  endtask

  task automatic test_double_div();
    idle(); issue_valid_i = 1'b1; issue_div_i = 1'b1; issue_rd_idx_i = 5'd2; settle();
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL ddiv_first_stall got %0b exp 0", stall_o); end
    tick(); issue_rd_idx_i = 5'd6; settle();
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL ddiv_busy1 got %0b exp 1", stall_o); end
    tick(); div_valid_i = 1'b1; div_value_i = 32'h22; settle();
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL ddiv_busy2 got %0b exp 1", stall_o); end
    tick(); div_valid_i = 1'b0; settle();
    tests++; if (wb_valid_o !== 1'b1 || wb_rd_idx_o !== 5'd2 || wb_value_o !== 32'h22) begin fails++;
      $display("FAIL ddiv_first_wb got v=%0b rd=%0d val=%h exp v=1 rd=2 val=22", wb_valid_o, wb_rd_idx_o, wb_value_o); end
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL ddiv_release got %0b exp 0", stall_o); end
    tick(); idle(); settle();
    tick(); div_valid_i = 1'b1; div_value_i = 32'h66; settle();
    tick(); div_valid_i = 1'b1; div_value_i = 32'hEE; settle();
    tests++; if (wb_valid_o !== 1'b1 || wb_rd_idx_o !== 5'd6 || wb_value_o !== 32'h66) begin fails++;
      $display("FAIL ddiv_second_wb got v=%0b rd=%0d val=%h exp v=1 rd=6 val=66", wb_valid_o, wb_rd_idx_o, wb_value_o); end
    tick(); idle(); settle();
    tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL ddiv_stray_pulse got %0b exp 0", wb_valid_o); end
  endtask

  task automatic test_reset_mid();
    idle(); issue_valid_i = 1'b1; issue_div_i = 1'b1; issue_rd_idx_i = 5'd12; settle();
    tick(); idle(); issue_valid_i = 1'b1; issue_mul_i = 1'b1; issue_rd_idx_i = 5'd13; settle();
    tick(); idle(); settle();
    tick(); rst_i = 1'b0; mul_value_i = 32'h13; settle();
    tick(); rst_i = 1'b1; issue_div_i = 1'b1; issue_ra_idx_i = 5'd12; settle();
    tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL rmid_wb_valid got %0b exp 0", wb_valid_o); end
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL rmid_stall got %0b exp 0", stall_o); end
    tick(); idle(); div_valid_i = 1'b1; div_value_i = 32'hCC; settle();
    tick(); idle(); settle();
    tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL rmid_late_div got %0b exp 0", wb_valid_o); end
    tick(); settle();
    tests++; if (wb_valid_o !== 1'b0) begin fails++; $display("FAIL rmid_quiet got %0b exp 0", wb_valid_o); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div_collision();
    test_hold();
    test_x0();
    test_double_div();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_base_writeback.md
RISCV_BASE_WRITEBACK -- requirements
Module: riscv_base_writeback

Interface
REQ-001 SHALL provide parameter MUL_LATENCY, default 2, cycles from multiplier issue to mul_value_i valid; only value 2 supported.
REQ-002 SHALL provide ports (name  direction  width  meaning):
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  synchronous, active-low reset.
- hold_i  in  1  pipeline freeze.
- issue_valid_i  in  1  instruction offered this cycle.
- issue_mul_i  in  1  offered op is MUL/MULH/MULHSU/MULHU.
- issue_div_i  in  1  offered op is a divide/remainder.
- issue_rd_idx_i  in  5  destination register.
- issue_ra_idx_i  in  5  source register A.
- issue_rb_idx_i  in  5  source register B.
- alu_value_i  in  32  ALU result for the offered op.
- mul_value_i  in  32  multiplier writeback value.
- div_valid_i  in  1  divider completion pulse.
- div_value_i  in  32  divider result.
- stall_o  out  1  offered op not accepted.
- wb_valid_o  out  1  register-file write enable.
- wb_rd_idx_o  out  5  write index.
- wb_value_o  out  32  write data.

Function
REQ-003 SHALL treat an op as accepted in cycle N when issue_valid_i=1, stall_o=0 and hold_i=0; otherwise it is not accepted.
REQ-004 SHALL track each accepted non-divide op through stage E1 (cycle N+1) then E2 (cycle N+2); each entry holds valid, rd, is_mul and the ALU value.
REQ-005 SHALL select, for an E2 entry, mul_value_i sampled in cycle N+2 when is_mul=1, else the ALU value captured at issue.
REQ-006 SHALL register the write port, so an E2 entry appears on wb_* in cycle N+3.
REQ-007 SHALL, on an accepted divide, record div_rd and set div_pending; no E1/E2 entry is created.
REQ-008 SHALL assert stall_o when issue_div_i=1 and div_pending=1.
REQ-009 SHALL assert stall_o when a nonzero issue_ra_idx_i or issue_rb_idx_i equals the rd of a valid E1 entry with is_mul=1, a valid E2 entry with is_mul=1, or div_rd while div_pending=1.
REQ-010 SHALL assert stall_o whenever the skid register is valid.
REQ-011 SHALL give writeback priority, highest first:
- E2 entry;
- skid register;
- div_valid_i in the same cycle.
REQ-012 SHALL capture div_valid_i into the skid register when it cannot be written in the same cycle (E2 valid or hold_i=1).
REQ-013 SHALL clear div_pending in the cycle its result is written to wb_*.
REQ-014 SHALL have at most one skid entry.
REQ-015 SHALL make a div_valid_i pulse with div_pending=0 a no-op.
REQ-016 SHALL drive wb_valid_o=0 when the winning entry has rd=0, while still consuming that entry.
REQ-017 SHALL, when hold_i=1:
- freeze E1, E2 and the wb_* registers;
- force wb_valid_o=0;
- still capture div_valid_i into the skid register.
REQ-018 SHALL keep stall_o combinational from the issue inputs and current state only.
REQ-019 SHALL release wb_* with wb_valid_o=0 in cycles with no winning entry; wb_rd_idx_o and wb_value_o hold their last values.

Reset
REQ-020 SHALL, when rst_i=0 at a clock edge, clear:
- E1/E2 valids;
- skid valid;
- div_pending;
- wb_valid_o, wb_rd_idx_o and wb_value_o (all to 0).
REQ-021 SHALL make stall_o 0 in the first cycle after reset.
REQ-022 SHALL discard in-flight multiplier, ALU and divider results on mid-operation reset; a later div_valid_i is ignored per REQ-015.

Verification
REQ-023 SHALL cover ALU passthrough: accept rd=5, alu_value_i=0x1234 at N -> wb_valid_o=1, rd=5, value 0x1234 at N+3.
REQ-024 SHALL cover MUL latency:
- accept MUL rd=7 at N; mul_value_i=0xF in N+2 -> wb rd=7, value 0xF at N+3;
- MUL with ra=7 at N+1 -> stall_o=1 in N+1 and N+2, accepted in N+3.
REQ-025 SHALL cover divider collision:
- DIV rd=3 pending; ALU rd=4 in E2 when div_valid_i=1, value 0x9 -> rd=4 written first, rd=3 value 0x9 next cycle;
- stall_o=1 while skid is valid.
REQ-026 SHALL cover hold: hold_i=1 for 3 cycles with a MUL in E1 -> wb_valid_o=0 throughout; result written 2 cycles after hold_i falls.
REQ-027 SHALL cover x0 and double-divide:
- rd=0 op -> no wb_valid_o pulse;
- second DIV while pending -> stall_o=1 until the first result is written.
REQ-028 SHALL cover mid-operation reset: rst_i=0 with MUL in E2 and DIV pending -> wb_valid_o=0 next cycle; later div_valid_i produces no write.
